// File: rtl/buzz_share_pkg.sv
// Shared types for the Buzz time-share arbiter: id/credit widths and the shadow-pipe stage.
// Package types cannot follow module parameters, so they are sized for the largest supported build.
package buzz_share_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned pow;
    result = 0;
    pow    = 1;
    while (pow < value) begin
      pow    = pow << 1;
      result = result + 1;
    end
    return result;
  endfunction

  // Supported limits: N_REQ <= MAX_REQ, DEPTH <= MAX_DEPTH
  localparam int unsigned MAX_REQ   = 256;
  localparam int unsigned MAX_DEPTH = 255;
  localparam int unsigned ID_W      = (clog2(MAX_REQ) > 0) ? clog2(MAX_REQ) : 1;
  localparam int unsigned CREDIT_W  = clog2(MAX_DEPTH + 1);

  typedef logic [ID_W-1:0]     id_t;
  typedef logic [CREDIT_W-1:0] credit_t;

  typedef struct packed {
    logic valid;
    id_t  id;
  } shadow_stage_t;

endpackage

// File: rtl/buzz_rsp_fifo.sv
// First-word fall-through response FIFO; the caller's credit scheme guarantees no overflow.
module buzz_rsp_fifo
  import buzz_share_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_rd;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      assert (!(wr_en && !do_rd && count == CNT_W'(DEPTH)));
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/buzz_share_arbiter.sv
// Shares one fixed-latency Buzz unit between N_REQ requesters: round-robin grant,
// shadow pipe tracking result ownership, credit-protected per-requester response FIFOs.
module buzz_share_arbiter
  import buzz_share_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned LAT   = 3,
  parameter int unsigned DEPTH = LAT + 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       buzz_I,
  input  logic [WIDTH-1:0]       buzz_O,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [N_REQ*WIDTH-1:0] rsp_data,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic                   idle
);

  id_t              rr_ptr;
  credit_t          credit [N_REQ];
  logic [N_REQ-1:0] elig_c;
  logic [N_REQ-1:0] grant_c;
  logic             grant_any_c;
  id_t              grant_id_c;
  logic [N_REQ-1:0] pop_c;
  logic [N_REQ-1:0] wr_en_c;
  logic [N_REQ-1:0] fifo_empty;
  logic             cap_valid_c;
  id_t              cap_id_c;
  logic             inflight_c;

  // Round-robin: first eligible at or after rr_ptr, otherwise first eligible below it
  always_comb begin
    elig_c      = '0;
    grant_c     = '0;
    grant_any_c = 1'b0;
    grant_id_c  = '0;
    buzz_I      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig_c[i] = !RESET && req_valid[i] && (credit[i] != '0);
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_any_c && elig_c[i] && (id_t'(i) >= rr_ptr)) begin
        grant_any_c = 1'b1;
        grant_id_c  = id_t'(i);
        grant_c[i]  = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_any_c && elig_c[i]) begin
        grant_any_c = 1'b1;
        grant_id_c  = id_t'(i);
        grant_c[i]  = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_c[i]) buzz_I = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign req_ready = grant_c;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_ptr <= '0;
    end else if (grant_any_c) begin
      rr_ptr <= (grant_id_c == id_t'(N_REQ - 1)) ? '0 : grant_id_c + id_t'(1);
    end
  end

  // Owner tracking mirrors Buzz latency; LAT=0 captures in the grant cycle
  if (LAT > 0) begin : g_shadow
    shadow_stage_t shadow [LAT];

    always_ff @(posedge CLK) begin
      if (RESET) begin
        for (int s = 0; s < LAT; s++) shadow[s] <= '0;
      end else begin
        shadow[0] <= '{valid: grant_any_c, id: grant_id_c};
        for (int s = 1; s < LAT; s++) shadow[s] <= shadow[s-1];
      end
    end

    always_comb begin
      inflight_c = 1'b0;
      for (int s = 0; s < LAT; s++) inflight_c = inflight_c | shadow[s].valid;
    end

    assign cap_valid_c = shadow[LAT-1].valid;
    assign cap_id_c    = shadow[LAT-1].id;
  end else begin : g_no_shadow
    assign cap_valid_c = grant_any_c;
    assign cap_id_c    = grant_id_c;
    assign inflight_c  = 1'b0;
  end

  // One credit per FIFO slot: taken on accept, returned on consumer pop
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (RESET) begin
        credit[i] <= credit_t'(DEPTH);
      end else begin
        case ({grant_c[i], pop_c[i]})
          2'b10:   credit[i] <= credit[i] - credit_t'(1);
          2'b01:   credit[i] <= credit[i] + credit_t'(1);
          default: ;
        endcase
        assert (!(grant_c[i] && !pop_c[i] && credit[i] == '0));
        assert (!(pop_c[i] && !grant_c[i] && credit[i] == credit_t'(DEPTH)));
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
    assign wr_en_c[g]   = cap_valid_c && (cap_id_c == id_t'(g));
    assign pop_c[g]     = rsp_valid[g] && rsp_ready[g];
    assign rsp_valid[g] = !fifo_empty[g];

    buzz_rsp_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .wr_en   (wr_en_c[g]),
      .wr_data (buzz_O),
      .rd_en   (pop_c[g]),
      .rd_data (rsp_data[g*WIDTH +: WIDTH]),
      .empty   (fifo_empty[g])
    );
  end

  assign idle = !inflight_c && (&fifo_empty);

endmodule
